// File: rtl/decoded_info_gearbox_pkg.sv
// decoded_info_gearbox_pkg: shared defaults, derived sizes and output FSM encoding
// for the decoded-word gearbox and its FIFO.
package decoded_info_gearbox_pkg;
  localparam int DEF_BLK_SIZE   = 127;
  localparam int DEF_PCM_COLN   = 32;
  localparam int DEF_INFO_COLN  = 24;
  localparam int DEF_OUT_WIDTH  = 32;
  localparam int DEF_FIFO_DEPTH = 64;
  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction
  localparam int BEATS   = ceil_div(DEF_BLK_SIZE, DEF_OUT_WIDTH);
  localparam int FIFO_AW = clog2_min1(DEF_FIFO_DEPTH);
  localparam int COL_AW  = clog2_min1(DEF_PCM_COLN);
  typedef enum logic {ST_IDLE, ST_SEND} state_t;
endpackage

// File: rtl/decoded_info_gearbox_info_fifo.sv
// info_fifo: synchronous FIFO with registered read data of the head entry.
// A newly written entry becomes readable (o_avail) one cycle after its write.
module info_fifo
  import decoded_info_gearbox_pkg::*;
#(
  parameter int WIDTH = DEF_BLK_SIZE + 1,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_wdata,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_rdata,
  output logic                         o_avail,
  output logic                         o_empty,
  output logic                         o_full,
  output logic [clog2_min1(DEPTH):0]   o_level
);
  localparam int AW = clog2_min1(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [AW:0]      r_cnt;
  logic [WIDTH-1:0] r_rdata;
  logic             r_wr;
  logic             w_push;
  assign o_full  = r_cnt == (AW+1)'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign w_push  = i_push && (!o_full || i_pop);
  assign o_avail = !o_empty && !(r_cnt == (AW+1)'(1) && r_wr);
  assign o_level = r_cnt;
  assign o_rdata = r_rdata;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wptr] <= i_wdata;
  // Head data is refreshed every cycle from the post-pop read pointer.
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      r_wr    <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_wptr  <= r_wptr + AW'(w_push);
      r_rptr  <= r_rptr + AW'(i_pop);
      r_cnt   <= r_cnt + (AW+1)'(w_push) - (AW+1)'(i_pop);
      r_wr    <= w_push;
      r_rdata <= r_mem[r_rptr + AW'(i_pop)];
    end
endmodule

// File: rtl/decoded_info_gearbox.sv
// decoded_info_gearbox: keeps the systematic words of each decoded frame and
// serialises them into OUT_WIDTH-bit valid/ready beats.
module decoded_info_gearbox
  import decoded_info_gearbox_pkg::*;
#(
  parameter int BLK_SIZE   = DEF_BLK_SIZE,
  parameter int PCM_COLN   = DEF_PCM_COLN,
  parameter int INFO_COLN  = DEF_INFO_COLN,
  parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BLK_SIZE-1:0]  i_decoded_info,
  input  logic                 i_decoded_info_valid,
  input  logic                 i_decoded_info_last,
  output logic [OUT_WIDTH-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_last,
  output logic                 o_overflow,
  output logic                 o_frame_err,
  output logic                 o_busy
);
  localparam int NB = ceil_div(BLK_SIZE, OUT_WIDTH);
  localparam int BW = clog2_min1(NB);
  localparam int CW = clog2_min1(PCM_COLN);
  localparam int LW = clog2_min1(FIFO_DEPTH) + 1;
  state_t                         r_state;
  logic [BW-1:0]                  r_beat;
  logic [CW-1:0]                  r_in_col;
  logic                           r_overflow, r_frame_err;
  logic [BLK_SIZE:0]              w_rdata;
  logic [NB-1:0][OUT_WIDTH-1:0]   w_pad;
  logic [LW-1:0]                  w_level;
  logic w_avail, w_empty, w_full, w_col_end, w_push, w_tag, w_last_beat, w_pop;
  assign w_col_end   = r_in_col == CW'(PCM_COLN - 1);
  assign w_push      = i_decoded_info_valid && 32'(r_in_col) < INFO_COLN;
  assign w_tag       = r_in_col == CW'(INFO_COLN - 1);
  assign w_last_beat = r_beat == BW'(NB - 1);
  assign w_pop       = r_state == ST_SEND && i_ready && w_last_beat;
  assign w_pad       = (NB*OUT_WIDTH)'(w_rdata[BLK_SIZE-1:0]);
  assign o_valid     = r_state == ST_SEND;
  assign o_data      = o_valid ? w_pad[r_beat] : '0;
  assign o_last      = o_valid && w_rdata[BLK_SIZE] && w_last_beat;
  assign o_overflow  = r_overflow;
  assign o_frame_err = r_frame_err;
  assign o_busy      = !w_empty || o_valid;
  // The word being serialised stays at the FIFO head until its final beat leaves.
  info_fifo #(.WIDTH(BLK_SIZE + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata ({w_tag, i_decoded_info}),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_avail (w_avail),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_level (w_level)
  );
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_beat      <= '0;
      r_in_col    <= '0;
      r_overflow  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (i_decoded_info_valid) begin
        r_in_col <= (i_decoded_info_last || w_col_end) ? '0 : r_in_col + 1'b1;
        if (i_decoded_info_last != w_col_end) r_frame_err <= 1'b1;
      end
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
      if (r_state == ST_IDLE) begin
        if (w_avail) begin
          r_state <= ST_SEND;
          r_beat  <= '0;
        end
      end else if (i_ready) begin
        r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
        // Continue straight into the next word when one is already behind the head.
        if (w_last_beat && w_level < LW'(2)) r_state <= ST_IDLE;
      end
    end
endmodule

// File: tb/tb_decoded_info_gearbox.sv
// tb_decoded_info_gearbox: table-driven frame scenarios plus a mid-word reset sequence.
module tb_decoded_info_gearbox;
  import decoded_info_gearbox_pkg::*;
  localparam int BLK  = DEF_BLK_SIZE;
  localparam int PCM  = DEF_PCM_COLN;
  localparam int INFO = DEF_INFO_COLN;
  localparam int OW   = DEF_OUT_WIDTH;
  localparam int PW   = BEATS * OW;

  typedef struct {
    string name;
    int    nframes;
    int    short_col;
    int    mode;
    int    cap;
    int    exp_beats;
    int    exp_lasts;
    int    exp_ovf;
    int    exp_ferr;
  } vec_t;

  logic           clk, rst_n;
  logic [BLK-1:0] i_decoded_info;
  logic           i_decoded_info_valid, i_decoded_info_last;
  logic [OW-1:0]  o_data;
  logic           o_valid, i_ready, o_last, o_overflow, o_frame_err, o_busy;

  int checks, failures, cyc_n, first_v, t_push;
  logic [OW-1:0] got_d[$], exp_d[$];
  logic          got_l[$], exp_l[$];
  int            got_c[$];
  logic          hold_pend, hold_l;
  logic [OW-1:0] hold_d;
  vec_t          vecs[6];

  decoded_info_gearbox dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .i_decoded_info       (i_decoded_info),
    .i_decoded_info_valid (i_decoded_info_valid),
    .i_decoded_info_last  (i_decoded_info_last),
    .o_data               (o_data),
    .o_valid              (o_valid),
    .i_ready              (i_ready),
    .o_last               (o_last),
    .o_overflow           (o_overflow),
    .o_frame_err          (o_frame_err),
    .o_busy               (o_busy)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Beat monitor and stall-stability checks, away from the active edge.
  initial begin
    hold_pend = 0;
    hold_d = '0;
    hold_l = 0;
  end
  always @(negedge clk) begin
    if (rst_n && hold_pend) begin
      chk("hold_data", 64'(o_data), 64'(hold_d));
      chk("hold_last", 64'(o_last), 64'(hold_l));
    end
    hold_pend <= rst_n && o_valid && !i_ready;
    hold_d    <= o_data;
    hold_l    <= o_last;
    if (o_valid && first_v < 0) first_v <= cyc_n;
    if (rst_n && o_valid && i_ready) begin
      got_d.push_back(o_data);
      got_l.push_back(o_last);
      got_c.push_back(cyc_n);
    end
  end

  function automatic logic [BLK-1:0] mkword(input int k);
    logic [127:0] t;
    t = {16{8'(k)}};
    return t[BLK-1:0];
  endfunction

  function automatic logic [OW-1:0] beat_of(input logic [BLK-1:0] w, input int b);
    logic [PW-1:0] p;
    p = '0;
    p[BLK-1:0] = w;
    p = p >> (b * OW);
    return p[OW-1:0];
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input int mode);
    cyc();
    if (mode == 1) i_ready = !i_ready;
  endtask

  task automatic clear_q();
    got_d.delete(); got_l.delete(); got_c.delete();
    exp_d.delete(); exp_l.delete();
    first_v = -1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    i_decoded_info_valid = 0;
    i_decoded_info_last = 0;
    cyc(); cyc();
    rst_n = 1;
  endtask

  task automatic run_vec(input vec_t v, input bit rst_first);
    int kept, dropped, ncols, nl, n;
    bit ferr, last;
    logic [BLK-1:0] w;
    clear_q();
    kept = 0; dropped = 0; ferr = 0; t_push = 0;
    i_ready = (v.mode == 2) ? 1'b0 : 1'b1;
    if (rst_first) do_reset();
    for (int f = 0; f < v.nframes; f++) begin
      ncols = (f == 0 && v.short_col >= 0) ? v.short_col + 1 : PCM;
      for (int c = 0; c < ncols; c++) begin
        last = (c == ncols - 1) && !(f == 0 && v.short_col == -2);
        w = mkword(f * 32 + c);
        i_decoded_info = w;
        i_decoded_info_valid = 1;
        i_decoded_info_last = last;
        if (c < INFO) begin
          if (kept < v.cap) begin
            kept++;
            for (int b = 0; b < BEATS; b++) begin
              exp_d.push_back(beat_of(w, b));
              exp_l.push_back(b == BEATS - 1 && c == INFO - 1);
            end
          end else dropped++;
        end
        if (last != (c == PCM - 1)) ferr = 1;
        step(v.mode);
        if (f == 0 && c == 0) t_push = cyc_n;
        chk({v.name, "_overflow"}, 64'(o_overflow), 64'(dropped > 0));
        chk({v.name, "_frame_err"}, 64'(o_frame_err), 64'(ferr));
      end
    end
    i_decoded_info_valid = 0;
    i_decoded_info_last = 0;
    i_decoded_info = '0;
    if (v.mode == 2) i_ready = 1;
    for (n = 0; n < 4000 && got_d.size() < exp_d.size(); n++) step(v.mode);
    repeat (8) step(v.mode);
    chk({v.name, "_beats"}, 64'(got_d.size()), 64'(v.exp_beats));
    chk({v.name, "_model_beats"}, 64'(exp_d.size()), 64'(v.exp_beats));
    nl = 0;
    foreach (got_l[i]) nl += int'(got_l[i]);
    chk({v.name, "_lasts"}, 64'(nl), 64'(v.exp_lasts));
    chk({v.name, "_latency"}, 64'(first_v - t_push), 64'(2));
    chk({v.name, "_ovf_end"}, 64'(o_overflow), 64'(v.exp_ovf));
    chk({v.name, "_ferr_end"}, 64'(o_frame_err), 64'(v.exp_ferr));
    chk({v.name, "_idle"}, 64'({o_busy, o_valid}), 64'(0));
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      chk($sformatf("%s_data%0d", v.name, i), 64'(got_d[i]), 64'(exp_d[i]));
      chk($sformatf("%s_last%0d", v.name, i), 64'(got_l[i]), 64'(exp_l[i]));
    end
    if (v.mode == 0 && got_c.size() > 0)
      chk({v.name, "_no_bubble"}, 64'(got_c[$] - got_c[0]), 64'(got_c.size() - 1));
  endtask

  initial begin
    checks = 0; failures = 0; first_v = -1; t_push = 0;
    rst_n = 0; i_ready = 0;
    i_decoded_info = '0; i_decoded_info_valid = 0; i_decoded_info_last = 0;
    cyc(); cyc();
    chk("reset_outs", 64'({o_valid, o_last, o_overflow, o_frame_err, o_busy, o_data}), 64'(0));
    rst_n = 1;

    vecs[0] = '{"one_frame",      1, -1, 0, 1000,  96, 1, 0, 0};
    vecs[1] = '{"ready_toggle",   1, -1, 1, 1000,  96, 1, 0, 0};
    vecs[2] = '{"stall_3_frames", 3, -1, 2,   64, 256, 2, 1, 0};
    vecs[3] = '{"short_frame",    2,  9, 0, 1000, 136, 1, 0, 1};
    vecs[4] = '{"missing_last",   2, -2, 0, 1000, 192, 2, 0, 1};
    vecs[5] = '{"two_frames",     2, -1, 0, 1000, 192, 2, 0, 0};
    foreach (vecs[i]) run_vec(vecs[i], 1);

    // Reset while word 5 is on its third beat, then a clean frame.
    clear_q();
    i_ready = 0;
    do_reset();
    for (int c = 0; c < PCM; c++) begin
      i_decoded_info = mkword(c);
      i_decoded_info_valid = 1;
      i_decoded_info_last = (c == PCM - 1);
      cyc();
    end
    i_decoded_info_valid = 0;
    i_decoded_info_last = 0;
    i_ready = 1;
    for (int n = 0; n < 200 && got_d.size() < 22; n++) cyc();
    chk("mid_beats_sent", 64'(got_d.size()), 64'(22));
    chk("mid_beat_data", 64'(o_data), 64'(beat_of(mkword(5), 2)));
    chk("mid_valid", 64'(o_valid), 64'(1));
    rst_n = 0;
    cyc();
    chk("mid_reset_outs", 64'({o_valid, o_last, o_overflow, o_frame_err, o_busy, o_data}), 64'(0));
    rst_n = 1;
    cyc();
    run_vec(vecs[0], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
